// File: rtl/sseg_pkg.sv
// Shared constants and helpers for the multiplexed hex seven-segment scan driver.
// All segment codes are active-low, ordered {g,f,e,d,c,b,a}.
package sseg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Counter width for a modulus n; a modulus of 1 or 2 still gets one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    if (n <= 32'd2) begin
      return 32'd1;
    end else begin
      return int'($clog2(n));
    end
  endfunction

  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/sseg_hex_decode.sv
// Combinational nibble to active-low seven-segment pattern.
module sseg_hex_decode
  import sseg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = hex2seg(nib_i);

endmodule

// File: rtl/sseg_nhex_scan.sv
// N-digit hex seven-segment scan driver with frame-synchronous loading,
// leading-zero blanking, per-digit enables, decimal points and anode dead time.
module sseg_nhex_scan
  import sseg_pkg::*;
#(
  parameter int unsigned DIGITS   = 32'd4,
  parameter int unsigned CLK_DIV  = 32'd100000,
  parameter int unsigned DEAD_CYC = 32'd16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [4*DIGITS-1:0]   HEX,
  input  logic [DIGITS-1:0]     DP_IN,
  input  logic [DIGITS-1:0]     DIG_EN,
  input  logic                  LZB,
  input  logic                  LOAD,
  output logic [6:0]            SEG,
  output logic                  dp,
  output logic [DIGITS-1:0]     AN,
  output logic                  FRAME
);

  localparam int unsigned        CNT_W    = cnt_width(CLK_DIV);
  localparam int unsigned        IDX_W    = cnt_width(DIGITS);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLK_DIV - 32'd1);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(DIGITS - 32'd1);
  localparam logic [DIGITS-1:0]  AN_ONE   = DIGITS'(1'b1);
  localparam logic [DIGITS-1:0]  AN_OFF   = {DIGITS{1'b1}};

  logic [CNT_W-1:0]    div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] disp_hex_q, disp_hex_d;
  logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [4*DIGITS-1:0] pend_hex_q, pend_hex_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                pend_q, pend_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                frame_q, frame_d;

  logic                wrap_s;
  logic                boundary_s;
  logic                dead_s;
  logic [3:0]          sel_nib_s;
  logic                sel_dp_s;
  logic                sel_en_s;
  logic                upper_nz_s;
  logic                blank_s;
  logic [6:0]          dec_seg_s;

  assign wrap_s     = (div_cnt_q == CNT_LAST);
  assign boundary_s = wrap_s && (idx_q == IDX_LAST);

  if (DEAD_CYC > 32'd0) begin : g_dead
    localparam logic [CNT_W-1:0] DEAD_LIM = CNT_W'(DEAD_CYC);
    assign dead_s = (div_cnt_q < DEAD_LIM);
  end else begin : g_no_dead
    assign dead_s = 1'b0;
  end

  // Slot divider and digit index; wraps are explicit compares so any DIGITS works.
  always_comb begin
    div_cnt_d = div_cnt_q;
    idx_d     = idx_q;
    if (wrap_s) begin
      div_cnt_d = {CNT_W{1'b0}};
      if (idx_q == IDX_LAST) begin
        idx_d = {IDX_W{1'b0}};
      end else begin
        idx_d = idx_q + IDX_W'(1'b1);
      end
    end else begin
      div_cnt_d = div_cnt_q + CNT_W'(1'b1);
    end
  end

  // Shadow loading: LOAD fills pending, a frame boundary promotes pending to the display.
  // A LOAD on the boundary cycle still promotes the old pending and keeps pend set.
  always_comb begin
    pend_hex_d = pend_hex_q;
    pend_dp_d  = pend_dp_q;
    pend_d     = pend_q;
    disp_hex_d = disp_hex_q;
    disp_dp_d  = disp_dp_q;
    frame_d    = 1'b0;
    if (boundary_s && pend_q) begin
      disp_hex_d = pend_hex_q;
      disp_dp_d  = pend_dp_q;
      frame_d    = 1'b1;
      pend_d     = 1'b0;
    end else begin
      frame_d = 1'b0;
    end
    if (LOAD) begin
      pend_hex_d = HEX;
      pend_dp_d  = DP_IN;
      pend_d     = 1'b1;
    end else begin
      pend_d = pend_d;
    end
  end

  // Select the current digit and decide whether any higher digit is nonzero.
  always_comb begin
    sel_nib_s  = 4'h0;
    sel_dp_s   = 1'b0;
    sel_en_s   = 1'b0;
    upper_nz_s = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      sel_nib_s  = (idx_q == IDX_W'(i)) ? disp_hex_q[4*i +: 4] : sel_nib_s;
      sel_dp_s   = (idx_q == IDX_W'(i)) ? disp_dp_q[i]         : sel_dp_s;
      sel_en_s   = (idx_q == IDX_W'(i)) ? DIG_EN[i]            : sel_en_s;
      upper_nz_s = upper_nz_s |
                   ((i >= int'(idx_q)) && (disp_hex_q[4*i +: 4] != 4'h0));
    end
  end

  assign blank_s = !sel_en_s || dead_s ||
                   (LZB && (idx_q != {IDX_W{1'b0}}) && !upper_nz_s);

  sseg_hex_decode u_dec (
    .nib_i (sel_nib_s),
    .seg_o (dec_seg_s)
  );

  // Next values for the registered display pins.
  always_comb begin
    seg_d = SEG_OFF;
    dp_d  = 1'b1;
    an_d  = AN_OFF;
    if (blank_s) begin
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
      an_d  = AN_OFF;
    end else begin
      seg_d = dec_seg_s;
      dp_d  = ~sel_dp_s;
      an_d  = ~(AN_ONE << idx_q);
    end
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_cnt_q  <= {CNT_W{1'b0}};
      idx_q      <= {IDX_W{1'b0}};
      disp_hex_q <= {(4*DIGITS){1'b0}};
      disp_dp_q  <= {DIGITS{1'b0}};
      pend_hex_q <= {(4*DIGITS){1'b0}};
      pend_dp_q  <= {DIGITS{1'b0}};
      pend_q     <= 1'b0;
      seg_q      <= SEG_OFF;
      dp_q       <= 1'b1;
      an_q       <= AN_OFF;
      frame_q    <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      idx_q      <= idx_d;
      disp_hex_q <= disp_hex_d;
      disp_dp_q  <= disp_dp_d;
      pend_hex_q <= pend_hex_d;
      pend_dp_q  <= pend_dp_d;
      pend_q     <= pend_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
      frame_q    <= frame_d;
    end
  end

  assign SEG   = seg_q;
  assign dp    = dp_q;
  assign AN    = an_q;
  assign FRAME = frame_q;

endmodule
